wasm_seq_alu: RTL and testbench

- Parametrised, handshaked successor to the combinational stack ALU in the WASM CPU datapath.
- Covers i32 and i64 (WIDTH=32/64) with the same operand convention: A = stack top, B = next, C = third; result = B op A.
- Single-cycle ops return a registered result one cycle after acceptance. mul/div/rem run on shared iterative datapaths.
- Adds WASM trap reporting, clz/ctz, and shift/rotate amounts taken modulo WIDTH.

---
 rtl/wasm_seq_alu_if.sv | 27 ++
 rtl/wasm_seq_alu.sv | 226 ++++++++++++++++++++++
 tb/tb_wasm_seq_alu.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/wasm_seq_alu_if.sv
// Handshake bundle for wasm_seq_alu: operation request channel plus registered result channel.
interface wasm_seq_alu_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             trap;
    logic [1:0]       trap_code;
    logic             busy;

    modport master (
        output in_valid, op, a, b, c, out_ready,
        input  in_ready, out_valid, result, trap, trap_code, busy
    );

    modport slave (
        input  in_valid, op, a, b, c, out_ready,
        output in_ready, out_valid, result, trap, trap_code, busy
    );
endinterface

// File: rtl/wasm_seq_alu.sv
// Handshaked WASM stack ALU: result = B op A, single-cycle ops registered, mul/div/rem iterative.
// Traps: divide by zero (code 1) and signed div overflow (code 2).
module wasm_seq_alu #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input logic           clk,
    input logic           rst,
    wasm_seq_alu_if.slave bus
);
    localparam int W = int'(WIDTH);
    localparam logic [WIDTH-1:0] MinNeg  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [SHW-1:0]   LastCnt = SHW'(WIDTH - 1);

    localparam logic [4:0] OpAdd  = 5'b00000, OpSub  = 5'b00001, OpAnd  = 5'b00010;
    localparam logic [4:0] OpOr   = 5'b00011, OpSel  = 5'b00100, OpEqz  = 5'b00101;
    localparam logic [4:0] OpEq   = 5'b00110, OpLtU  = 5'b00111, OpGtU  = 5'b01000;
    localparam logic [4:0] OpLeU  = 5'b01001, OpGeU  = 5'b01010, OpLtS  = 5'b01011;
    localparam logic [4:0] OpGtS  = 5'b01100, OpLeS  = 5'b01101, OpGeS  = 5'b01110;
    localparam logic [4:0] OpNe   = 5'b01111, OpShl  = 5'b10000, OpShrS = 5'b10001;
    localparam logic [4:0] OpShrU = 5'b10010, OpRotl = 5'b10011, OpRotr = 5'b10100;
    localparam logic [4:0] OpMul  = 5'b10101, OpDivS = 5'b10110, OpDivU = 5'b10111;
    localparam logic [4:0] OpXor  = 5'b11000, OpRemS = 5'b11001, OpRemU = 5'b11010;
    localparam logic [4:0] OpPop  = 5'b11011, OpClz  = 5'b11100, OpCtz  = 5'b11101;

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;
    state_e state_q, state_d;

    logic             out_valid_q, out_valid_d, trap_q, trap_d;
    logic [1:0]       code_q, code_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [4:0]       op_q, op_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             negq_q, negq_d, negr_q, negr_d;
    // acc: product accumulator / partial remainder; opa: multiplicand / divisor magnitude;
    // opb: multiplier / dividend shifting into quotient.
    logic [WIDTH-1:0] acc_q, acc_d, opa_q, opa_d, opb_q, opb_d;

    logic in_ready, busy, in_fire, out_fire, is_div, is_sgn, div_ovf, last;
    logic [WIDTH-1:0] alu_res, quo_next, rem_next;
    logic [WIDTH:0]   trial;
    logic [SHW-1:0]   sh, nsh;
    logic [SHW:0]     pop, clz, ctz;

    assign in_fire  = bus.in_valid && in_ready;
    assign out_fire = out_valid_q && bus.out_ready;
    assign is_div   = (bus.op == OpDivS) || (bus.op == OpDivU) ||
                      (bus.op == OpRemS) || (bus.op == OpRemU);
    assign is_sgn   = (bus.op == OpDivS) || (bus.op == OpRemS);
    assign div_ovf  = (bus.op == OpDivS) && (bus.b == MinNeg) && (bus.a == '1);
    assign last     = (cnt_q == LastCnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (in_fire) begin
                if (bus.op == OpMul) state_d = StMul;
                else if (is_div && bus.a != '0 && !div_ovf) state_d = StDiv;
            end
            StMul, StDiv: if (last) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready = (state_q == StIdle) && (!out_valid_q || bus.out_ready);
        busy     = (state_q != StIdle);
    end

    always_comb begin
        sh  = bus.a[SHW-1:0];
        nsh = -sh;
        pop = '0;
        clz = (SHW+1)'(WIDTH);
        ctz = (SHW+1)'(WIDTH);
        for (int i = 0; i < W; i++) begin
            pop = pop + (SHW+1)'(bus.a[i]);
            if (bus.a[i]) clz = (SHW+1)'(W - 1 - i);
        end
        for (int i = W - 1; i >= 0; i--) begin
            if (bus.a[i]) ctz = (SHW+1)'(i);
        end
        case (bus.op)
            OpAdd:   alu_res = bus.b + bus.a;
            OpSub:   alu_res = bus.b - bus.a;
            OpAnd:   alu_res = bus.b & bus.a;
            OpOr:    alu_res = bus.b | bus.a;
            OpXor:   alu_res = bus.b ^ bus.a;
            OpSel:   alu_res = (bus.a == '0) ? bus.c : bus.b;
            OpEqz:   alu_res = WIDTH'(bus.a == '0);
            OpEq:    alu_res = WIDTH'(bus.b == bus.a);
            OpNe:    alu_res = WIDTH'(bus.b != bus.a);
            OpLtU:   alu_res = WIDTH'(bus.b < bus.a);
            OpGtU:   alu_res = WIDTH'(bus.b > bus.a);
            OpLeU:   alu_res = WIDTH'(bus.b <= bus.a);
            OpGeU:   alu_res = WIDTH'(bus.b >= bus.a);
            OpLtS:   alu_res = WIDTH'($signed(bus.b) < $signed(bus.a));
            OpGtS:   alu_res = WIDTH'($signed(bus.b) > $signed(bus.a));
            OpLeS:   alu_res = WIDTH'($signed(bus.b) <= $signed(bus.a));
            OpGeS:   alu_res = WIDTH'($signed(bus.b) >= $signed(bus.a));
            OpShl:   alu_res = bus.b << sh;
            OpShrU:  alu_res = bus.b >> sh;
            OpShrS:  alu_res = $signed(bus.b) >>> sh;
            OpRotl:  alu_res = (sh == '0) ? bus.b : ((bus.b << sh) | (bus.b >> nsh));
            OpRotr:  alu_res = (sh == '0) ? bus.b : ((bus.b >> sh) | (bus.b << nsh));
            OpPop:   alu_res = WIDTH'(pop);
            OpClz:   alu_res = WIDTH'(clz);
            OpCtz:   alu_res = WIDTH'(ctz);
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q && !out_fire;
        result_d    = result_q;
        trap_d      = trap_q;
        code_d      = code_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        negq_d      = negq_q;
        negr_d      = negr_q;
        acc_d       = acc_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        trial       = {acc_q, opb_q[WIDTH-1]} - {1'b0, opa_q};
        quo_next    = '0;
        rem_next    = '0;
        unique case (state_q)
            StIdle: if (in_fire) begin
                op_d  = bus.op;
                cnt_d = '0;
                acc_d = '0;
                if (bus.op == OpMul) begin
                    opa_d = bus.b;
                    opb_d = bus.a;
                end else if (is_div && (bus.a == '0 || div_ovf)) begin
                    out_valid_d = 1'b1;
                    result_d    = '0;
                    trap_d      = 1'b1;
                    code_d      = (bus.a == '0) ? 2'd1 : 2'd2;
                end else if (is_div) begin
                    opa_d  = (is_sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
                    opb_d  = (is_sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
                    negq_d = is_sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    negr_d = is_sgn && bus.b[WIDTH-1];
                end else begin
                    out_valid_d = 1'b1;
                    result_d    = alu_res;
                    trap_d      = 1'b0;
                    code_d      = 2'd0;
                end
            end
            StMul: begin
                acc_d = acc_q + (opb_q[0] ? opa_q : '0);
                opa_d = opa_q << 1;
                opb_d = opb_q >> 1;
                cnt_d = cnt_q + SHW'(1);
                if (last) begin
                    out_valid_d = 1'b1;
                    result_d    = acc_d;
                    trap_d      = 1'b0;
                    code_d      = 2'd0;
                end
            end
            StDiv: begin
                if (!trial[WIDTH]) begin
                    acc_d = trial[WIDTH-1:0];
                    opb_d = {opb_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {acc_q[WIDTH-2:0], opb_q[WIDTH-1]};
                    opb_d = {opb_q[WIDTH-2:0], 1'b0};
                end
                cnt_d    = cnt_q + SHW'(1);
                quo_next = negq_q ? -opb_d : opb_d;
                rem_next = negr_q ? -acc_d : acc_d;
                if (last) begin
                    out_valid_d = 1'b1;
                    result_d    = (op_q == OpRemS || op_q == OpRemU) ? rem_next : quo_next;
                    trap_d      = 1'b0;
                    code_d      = 2'd0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            trap_q      <= 1'b0;
            code_q      <= 2'd0;
            op_q        <= '0;
            cnt_q       <= '0;
            negq_q      <= 1'b0;
            negr_q      <= 1'b0;
            acc_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            trap_q      <= trap_d;
            code_q      <= code_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            negq_q      <= negq_d;
            negr_q      <= negr_d;
            acc_q       <= acc_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.busy      = busy;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.trap      = trap_q;
    assign bus.trap_code = code_q;
endmodule

// File: tb/tb_wasm_seq_alu.sv
// Directed bench for wasm_seq_alu: 32-bit and 64-bit instances share clock and reset.
module tb_wasm_seq_alu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    wasm_seq_alu_if #(.WIDTH(32)) i32 ();
    wasm_seq_alu_if #(.WIDTH(64)) i64 ();

    wasm_seq_alu #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(i32.slave));
    wasm_seq_alu #(.WIDTH(64)) u_dut64 (.clk(clk), .rst(rst), .bus(i64.slave));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Offer one op on the 32-bit instance; returns #1 after its acceptance edge.
    task automatic op32(input logic [4:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] cv);
        i32.op = o; i32.a = av; i32.b = bv; i32.c = cv; i32.in_valid = 1'b1;
        @(posedge clk); #1;
        i32.in_valid = 1'b0;
    endtask

    task automatic wait32(output int lat);
        lat = 1;
        while (!i32.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic res32(input string tag, input logic [31:0] exp);
        chk({tag, "_valid"}, {63'd0, i32.out_valid}, 64'd1);
        chk(tag, {32'd0, i32.result}, {32'd0, exp});
    endtask

    initial begin
        int lat;
        int bad;
        i32.in_valid = 0; i32.op = '0; i32.a = '0; i32.b = '0; i32.c = '0; i32.out_ready = 1;
        i64.in_valid = 0; i64.op = '0; i64.a = '0; i64.b = '0; i64.c = '0; i64.out_ready = 1;

        @(posedge clk); #1;
        chk("rst_out_valid", {63'd0, i32.out_valid}, 64'd0);
        chk("rst_result", {32'd0, i32.result}, 64'd0);
        chk("rst_trap", {62'd0, i32.trap, i32.trap_code[0]}, 64'd0);
        chk("rst_busy64", {63'd0, i64.busy}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        chk("idle_in_ready", {63'd0, i32.in_ready}, 64'd1);
        op32(5'b00000, 32'd5, 32'd7, 32'd0);
        res32("add", 32'd12);
        op32(5'b00001, 32'd1, 32'd0, 32'd0);
        res32("sub_wrap", 32'hFFFF_FFFF);
        op32(5'b10011, 32'd33, 32'h8000_0001, 32'd0);
        res32("rotl33", 32'h0000_0003);
        op32(5'b10001, 32'd31, 32'h8000_0000, 32'd0);
        res32("shr_s31", 32'hFFFF_FFFF);
        op32(5'b10100, 32'd0, 32'h1234_5678, 32'd0);
        res32("rotr0", 32'h1234_5678);
        op32(5'b01011, 32'd1, 32'hFFFF_FFFF, 32'd0);
        res32("lt_s", 32'd1);
        op32(5'b00111, 32'd1, 32'hFFFF_FFFF, 32'd0);
        res32("lt_u", 32'd0);
        op32(5'b00100, 32'd0, 32'hBB, 32'hAA);
        res32("select", 32'hAA);
        op32(5'b11011, 32'h0000_F0F0, 32'd0, 32'd0);
        res32("popcnt", 32'd8);

        op32(5'b10110, 32'd2, 32'hFFFF_FFF9, 32'd0);
        chk("div_busy", {62'd0, i32.busy, i32.in_ready}, 64'd2);
        wait32(lat);
        chk("div_latency", 64'(lat), 64'd33);
        res32("div_s", 32'hFFFF_FFFD);
        op32(5'b11001, 32'd2, 32'hFFFF_FFF9, 32'd0);
        wait32(lat);
        res32("rem_s", 32'hFFFF_FFFF);
        op32(5'b10111, 32'd7, 32'd100, 32'd0);
        wait32(lat);
        res32("div_u", 32'd14);
        op32(5'b11010, 32'd7, 32'd100, 32'd0);
        wait32(lat);
        res32("rem_u", 32'd2);

        op32(5'b10111, 32'd0, 32'd7, 32'd0);
        res32("divz_result", 32'd0);
        chk("divz_trap", {61'd0, i32.trap, i32.trap_code}, 64'b101);
        op32(5'b10110, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        res32("ovf_result", 32'd0);
        chk("ovf_trap", {61'd0, i32.trap, i32.trap_code}, 64'b110);
        op32(5'b11001, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        wait32(lat);
        res32("rem_min", 32'd0);
        chk("rem_min_trap", {61'd0, i32.trap, i32.trap_code}, 64'd0);

        i64.op = 5'b10101; i64.a = '1; i64.b = 64'd3; i64.in_valid = 1'b1;
        @(posedge clk); #1;
        i64.in_valid = 1'b0;
        bad = 0;
        for (int k = 1; k <= 64; k++) begin
            if (i64.busy !== 1'b1 || i64.in_ready !== 1'b0 || i64.out_valid !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        chk("mul64_busy_cycles", 64'(bad), 64'd0);
        chk("mul64_valid", {62'd0, i64.out_valid, i64.busy}, 64'b10);
        chk("mul64_result", i64.result, 64'hFFFF_FFFF_FFFF_FFFD);

        i32.out_ready = 1'b0;
        op32(5'b00000, 32'd2, 32'd3, 32'd0);
        i32.op = 5'b00000; i32.a = 32'd10; i32.b = 32'd20; i32.in_valid = 1'b1;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (i32.out_valid !== 1'b1 || i32.result !== 32'd5 || i32.in_ready !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        chk("backpressure_hold", 64'(bad), 64'd0);
        i32.out_ready = 1'b1;
        #1;
        chk("bp_in_ready", {63'd0, i32.in_ready}, 64'd1);
        @(posedge clk); #1;
        i32.in_valid = 1'b0;
        res32("bp_new_add", 32'd30);

        op32(5'b10111, 32'd3, 32'd1000, 32'd0);
        repeat (9) begin @(posedge clk); #1; end
        chk("mid_div_busy", {63'd0, i32.busy}, 64'd1);
        rst = 1'b1;
        #1;
        chk("async_rst", {62'd0, i32.busy, i32.out_valid}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (40) begin @(posedge clk); #1; end
        chk("aborted_not_reported", {63'd0, i32.out_valid}, 64'd0);

        op32(5'b11100, 32'd0, 32'd0, 32'd0);
        res32("clz0", 32'd32);
        op32(5'b11101, 32'h8, 32'd0, 32'd0);
        res32("ctz8", 32'd3);
        i64.op = 5'b11100; i64.a = '0; i64.in_valid = 1'b1;
        @(posedge clk); #1;
        i64.in_valid = 1'b0;
        chk("clz64_0", i64.result, 64'd64);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
